// File: rtl/aes_decrypt_core.sv
// Iterative AES-256 decryption core: one inverse round per clock, round keys read 14..0
// from a fixed schedule ROM; done/busy handshake identical to the encryption core.

package aes_dec_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box as inverse-then-affine; a^254 is the field inverse (0 maps to 0).
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [255:0][7:0] inv_sbox_table();
    logic [255:0][7:0] t;
    t = '0;
    for (int i = 0; i < 256; i++) t[sbox(8'(i))] = 8'(i);
    return t;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [14:0][127:0] expand_key(input logic [255:0] key);
    logic [59:0][31:0] w;
    logic [14:0][127:0] rk;
    logic [31:0] tmp;
    logic [7:0]  rcon;
    w    = '0;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (i % 8 == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  // Byte k = 4*col + row sits at bits [127-8k -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

module aes_inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [255:0][7:0] TBL = aes_dec_pkg::inv_sbox_table();
  assign y_o = TBL[a_i];
endmodule

module round_keys (
  input  logic [3:0]   sel,
  output logic [127:0] key
);
  localparam logic [255:0] CIPHER_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [14:0][127:0] RK = aes_dec_pkg::expand_key(CIPHER_KEY);
  always_comb key = (sel <= 4'd14) ? RK[sel] : '0;
endmodule

module aes_decrypt_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cypher_text_in,
  output logic         statue,
  output logic [127:0] plaintext_out,
  output logic         busy
);
  import aes_dec_pkg::*;

  localparam int NUM_LANES = 16;

  logic [127:0] state_q, state_d, pt_d;
  logic [4:0]   count_q, count_d;
  logic         statue_next_q, done_d;
  logic [3:0]   ki;
  logic [127:0] rk, srow, t, nxt;
  logic [NUM_LANES-1:0][7:0] sub;

  // Idle reads index 14 for the initial whitening key, then rounds walk 13..0.
  assign ki   = 4'd14 - count_q[3:0];
  assign busy = (count_q != 5'd0);

  round_keys u_rk (.sel(ki), .key(rk));

  aes_inv_sbox u_isb [NUM_LANES-1:0] (.a_i(srow), .y_o(sub));

  always_comb begin
    srow = inv_shift_rows(state_q);
    t    = sub ^ rk;
    nxt  = (count_q == 5'd14) ? t : inv_mix_columns(t);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pt_d    = plaintext_out;
    done_d  = 1'b0;
    if (count_q == 5'd0) begin
      if (start) begin
        state_d = cypher_text_in ^ rk;
        count_d = 5'd1;
      end
    end else if (count_q < 5'd14) begin
      state_d = nxt;
      count_d = count_q + 5'd1;
    end else if (count_q == 5'd14) begin
      state_d = nxt;
      pt_d    = nxt;
      done_d  = 1'b1;
      count_d = 5'd0;
    end else begin
      count_d = 5'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= '0;
      count_q       <= '0;
      plaintext_out <= '0;
      statue_next_q <= 1'b0;
      statue        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      plaintext_out <= pt_d;
      statue_next_q <= done_d;
      statue        <= statue_next_q;
    end
  end

endmodule
